// File: rtl/gps_nmea_pkg.sv
// Shared NMEA definitions: ASCII symbols, numeric limits, sentence byte map
// and the sentence generator state type, common to the generator and parser.
package gps_nmea_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_G      = 8'h47;
  localparam logic [7:0] ASCII_P      = 8'h50;
  localparam logic [7:0] ASCII_A      = 8'h41;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_N      = 8'h4E;
  localparam logic [7:0] ASCII_S      = 8'h53;
  localparam logic [7:0] ASCII_E      = 8'h45;
  localparam logic [7:0] ASCII_W      = 8'h57;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  localparam int          NMEA_DIGITS  = 8;
  localparam logic [31:0] NMEA_MAX_VAL = 32'd99999999;
  localparam int          BCD_W        = 4 * NMEA_DIGITS;
  localparam int          BCD_BIN_W    = 27;
  localparam int          BCD_CYCLES   = 27;

  // Byte positions inside "$GPGGA,,dddddddd,N,dddddddd,E*hh\r\n"
  localparam logic [5:0] IDX_LAT_FIRST = 6'd8;
  localparam logic [5:0] IDX_LAT_LAST  = 6'd15;
  localparam logic [5:0] IDX_NS        = 6'd17;
  localparam logic [5:0] IDX_LON_FIRST = 6'd19;
  localparam logic [5:0] IDX_LON_LAST  = 6'd26;
  localparam logic [5:0] IDX_EW        = 6'd28;
  localparam logic [5:0] IDX_STAR      = 6'd29;
  localparam logic [5:0] IDX_CS_HI     = 6'd30;
  localparam logic [5:0] IDX_CS_LO     = 6'd31;
  localparam logic [5:0] IDX_CR        = 6'd32;
  localparam logic [5:0] IDX_LF        = 6'd33;

  localparam int SENT_LEN_BASE = 32;
  localparam int SENT_LEN_CRLF = 34;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_CONVERT,
    GEN_EMIT
  } gen_state_e;

  function automatic logic [BCD_BIN_W-1:0] nmea_saturate(input logic [31:0] v);
    logic [31:0] s;
    s = (v > NMEA_MAX_VAL) ? NMEA_MAX_VAL : v;
    return s[BCD_BIN_W-1:0];
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_ZERO + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Digit position 0 is the most significant BCD digit
  function automatic logic [7:0] bcd_char(input logic [BCD_W-1:0] bcd, input logic [2:0] pos);
    logic [3:0] d;
    d = bcd[4*(3'd7 - pos) +: 4];
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: 27-bit binary to 8 packed BCD digits, one shift
// per cycle, result valid exactly 27 cycles after start.
module bin2bcd8
  import gps_nmea_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [BCD_BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0]     bcd_o,
  output logic                 done_o
);

  logic [BCD_BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-1:0]     adj;
  logic [4:0]           cnt_q, cnt_d;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NMEA_DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = 5'(BCD_CYCLES);
    end else if (cnt_q != 5'd0) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (cnt_q == 5'd0);

endmodule

// File: rtl/nmea_sentence_gen.sv
// Formats a lat/lon pair as a $GPGGA sentence with XOR checksum and streams
// it byte-by-byte to the UART transmitter over valid/ready.
module nmea_sentence_gen
  import gps_nmea_pkg::*;
#(
  parameter bit EMIT_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_i,
  input  logic [31:0] latitude_i,
  input  logic [31:0] longitude_i,
  input  logic        lat_south_i,
  input  logic        lon_west_i,
  output logic [7:0]  uart_data_o,
  output logic        uart_valid_o,
  input  logic        uart_ready_i,
  output logic        busy_o,
  output logic        sent_o
);

  localparam int         NBYTES   = EMIT_CRLF ? SENT_LEN_CRLF : SENT_LEN_BASE;
  localparam logic [5:0] LAST_IDX = 6'(NBYTES - 1);

  gen_state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] csum_q, csum_d;
  logic       south_q, south_d;
  logic       west_q, west_d;
  logic       sent_q, sent_d;

  logic                 conv_start;
  logic [BCD_BIN_W-1:0] lat_sat, lon_sat;
  logic [BCD_W-1:0]     lat_bcd, lon_bcd;
  logic                 lat_done, lon_done;
  logic [7:0]           byte_mux;

  assign lat_sat = nmea_saturate(latitude_i);
  assign lon_sat = nmea_saturate(longitude_i);

  // Both converters load on the accept edge, so they also act as the input capture
  bin2bcd8 u_lat_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (lat_sat),
    .bcd_o   (lat_bcd),
    .done_o  (lat_done)
  );

  bin2bcd8 u_lon_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (lon_sat),
    .bcd_o   (lon_bcd),
    .done_o  (lon_done)
  );

  always_comb begin
    byte_mux = 8'h00;
    if (idx_q >= IDX_LAT_FIRST && idx_q <= IDX_LAT_LAST) begin
      byte_mux = bcd_char(lat_bcd, 3'(idx_q - IDX_LAT_FIRST));
    end else if (idx_q >= IDX_LON_FIRST && idx_q <= IDX_LON_LAST) begin
      byte_mux = bcd_char(lon_bcd, 3'(idx_q - IDX_LON_FIRST));
    end else begin
      case (idx_q)
        6'd0:                        byte_mux = ASCII_DOLLAR;
        6'd1, 6'd3, 6'd4:            byte_mux = ASCII_G;
        6'd2:                        byte_mux = ASCII_P;
        6'd5:                        byte_mux = ASCII_A;
        6'd6, 6'd7, 6'd16, 6'd18,
        6'd27:                       byte_mux = ASCII_COMMA;
        IDX_NS:                      byte_mux = south_q ? ASCII_S : ASCII_N;
        IDX_EW:                      byte_mux = west_q ? ASCII_W : ASCII_E;
        IDX_STAR:                    byte_mux = ASCII_STAR;
        IDX_CS_HI:                   byte_mux = hex_char(csum_q[7:4]);
        IDX_CS_LO:                   byte_mux = hex_char(csum_q[3:0]);
        IDX_CR:                      byte_mux = ASCII_CR;
        IDX_LF:                      byte_mux = ASCII_LF;
        default:                     byte_mux = 8'h00;
      endcase
    end
  end

  // Checksum folds in every transferred byte strictly between '$' and '*'
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    south_d    = south_q;
    west_d     = west_q;
    sent_d     = 1'b0;
    conv_start = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        if (send_i) begin
          state_d    = GEN_CONVERT;
          conv_start = 1'b1;
          south_d    = lat_south_i;
          west_d     = lon_west_i;
          csum_d     = 8'h00;
          idx_d      = 6'd0;
        end
      end
      GEN_CONVERT: begin
        if (lat_done && lon_done) begin
          state_d = GEN_EMIT;
        end
      end
      GEN_EMIT: begin
        if (uart_ready_i) begin
          if (idx_q != 6'd0 && idx_q < IDX_STAR) begin
            csum_d = csum_q ^ byte_mux;
          end
          if (idx_q == LAST_IDX) begin
            state_d = GEN_IDLE;
            idx_d   = 6'd0;
            sent_d  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GEN_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      south_q <= 1'b0;
      west_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      south_q <= south_d;
      west_q  <= west_d;
      sent_q  <= sent_d;
    end
  end

  assign uart_valid_o = (state_q == GEN_EMIT);
  assign uart_data_o  = (state_q == GEN_EMIT) ? byte_mux : 8'h00;
  assign busy_o       = (state_q != GEN_IDLE);
  assign sent_o       = sent_q;

endmodule

// File: tb/tb_nmea_sentence_gen.sv
// Self-checking bench for nmea_sentence_gen: a string-level sentence model
// is compared against the byte stream captured from the UART handshake.
module tb_nmea_sentence_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send, send0;
  logic [31:0] latitude, longitude;
  logic        latSouth, lonWest;
  logic        uartReady, ready0;
  logic [7:0]  uartData, data0;
  logic        uartValid, valid0, busy, busy0, sent, sent0;

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];

  always #5 clk = ~clk;

  nmea_sentence_gen #(.EMIT_CRLF(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .send_i(send),
    .latitude_i(latitude), .longitude_i(longitude),
    .lat_south_i(latSouth), .lon_west_i(lonWest),
    .uart_data_o(uartData), .uart_valid_o(uartValid), .uart_ready_i(uartReady),
    .busy_o(busy), .sent_o(sent)
  );

  nmea_sentence_gen #(.EMIT_CRLF(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .send_i(send0),
    .latitude_i(latitude), .longitude_i(longitude),
    .lat_south_i(latSouth), .lon_west_i(lonWest),
    .uart_data_o(data0), .uart_valid_o(valid0), .uart_ready_i(ready0),
    .busy_o(busy0), .sent_o(sent0)
  );

  function automatic longint pow10(input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Reference: build the sentence text from its field rules
  task automatic build_expected(input logic [31:0] lat, input logic [31:0] lon,
                                input bit s, input bit w, input bit crlf);
    logic [7:0] body[$];
    logic [7:0] cs;
    string hdr, hexd;
    longint v;
    hdr  = "GPGGA,,";
    hexd = "0123456789ABCDEF";
    for (int i = 0; i < hdr.len(); i++) body.push_back(hdr[i]);
    v = (lat > 32'd99999999) ? 64'd99999999 : longint'(lat);
    for (int k = 7; k >= 0; k--) body.push_back(8'(48 + (v / pow10(k)) % 10));
    body.push_back(",");
    body.push_back(s ? "S" : "N");
    body.push_back(",");
    v = (lon > 32'd99999999) ? 64'd99999999 : longint'(lon);
    for (int k = 7; k >= 0; k--) body.push_back(8'(48 + (v / pow10(k)) % 10));
    body.push_back(",");
    body.push_back(w ? "W" : "E");
    cs = 8'h00;
    foreach (body[i]) cs = cs ^ body[i];
    expQ.delete();
    expQ.push_back("$");
    foreach (body[i]) expQ.push_back(body[i]);
    expQ.push_back("*");
    expQ.push_back(hexd[cs[7:4]]);
    expQ.push_back(hexd[cs[3:0]]);
    if (crlf) begin
      expQ.push_back(8'h0D);
      expQ.push_back(8'h0A);
    end
  endtask

  function automatic string q2str(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, (q[i] >= 8'h20 && q[i] < 8'h7F) ? $sformatf("%c", q[i]) : "."};
    return s;
  endfunction

  function automatic bit seq_match();
    if (gotQ.size() != expQ.size()) return 1'b0;
    foreach (expQ[i]) if (gotQ[i] !== expQ[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_send(input logic [31:0] lat, input logic [31:0] lon,
                            input bit s, input bit w);
    @(negedge clk);
    latitude  = lat;
    longitude = lon;
    latSouth  = s;
    lonWest   = w;
    send      = 1'b1;
    @(posedge clk);
  endtask

  // cyc 0 is the negedge right after the accept edge
  task automatic collect(input bit randReady, input bit disturb, input int tail,
                         output int firstValid, output int sentAt, output int sentCount,
                         output int stallErr, output logic busyStart);
    bit prevStall;
    logic [7:0] prevData;
    gotQ.delete();
    firstValid = -1; sentAt = -1; sentCount = 0; stallErr = 0;
    prevStall = 1'b0; prevData = 8'h00; busyStart = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      send = 1'b0;
      if (cyc == 0) busyStart = busy;
      if (disturb && (cyc == 10 || cyc == 45)) begin
        send      = 1'b1;
        latitude  = $urandom;
        longitude = $urandom;
        latSouth  = ~latSouth;
      end
      if (prevStall && (uartValid !== 1'b1 || uartData !== prevData)) stallErr++;
      if (uartValid === 1'b1 && firstValid < 0) firstValid = cyc;
      if (sent === 1'b1) begin
        sentCount++;
        if (sentAt < 0) sentAt = cyc;
      end
      if (sentAt >= 0 && cyc >= sentAt + tail) break;
      uartReady = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (uartValid === 1'b1 && uartReady) gotQ.push_back(uartData);
      prevStall = (uartValid === 1'b1) && !uartReady;
      prevData  = uartData;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (uartData !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", uartData); end
    total++; if (uartValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", uartValid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (sent !== 1'b0) begin bad++; $display("[TB] FAIL reset_sent got=%b exp=0", sent); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_vectors();
    logic [31:0] latV[3];
    logic        southV[3];
    string       csV[3];
    string       c;
    int fv, sa, sc, se;
    logic bs;
    latV   = '{32'd0, 32'd12345678, 32'hFFFFFFFF};
    southV = '{1'b0, 1'b1, 1'b0};
    csV    = '{"71", "64", "71"};
    for (int v = 0; v < 3; v++) begin
      build_expected(latV[v], 32'd0, southV[v], 1'b0, 1'b1);
      start_send(latV[v], 32'd0, southV[v], 1'b0);
      collect(1'b0, 1'b0, 0, fv, sa, sc, se, bs);
      total++;
      if (!seq_match()) begin
        bad++; $display("[TB] FAIL fixed%0d_bytes got=%s exp=%s", v, q2str(gotQ), q2str(expQ));
      end
      c = csV[v];
      total++;
      if (gotQ.size() < 32 || gotQ[30] !== c[0] || gotQ[31] !== c[1]) begin
        bad++; $display("[TB] FAIL fixed%0d_checksum got=%s exp=%s", v, q2str(gotQ), c);
      end
      total++; if (bs !== 1'b1) begin bad++; $display("[TB] FAIL fixed%0d_busy_rise got=%b exp=1", v, bs); end
      total++; if (fv != 28) begin bad++; $display("[TB] FAIL fixed%0d_first_valid got=%0d exp=28", v, fv); end
      total++;
      if (sa != 28 + expQ.size()) begin
        bad++; $display("[TB] FAIL fixed%0d_sent_time got=%0d exp=%0d", v, sa, 28 + expQ.size());
      end
      @(negedge clk);
      total++;
      if (sent !== 1'b0 || busy !== 1'b0 || uartValid !== 1'b0 || sc != 1) begin
        bad++; $display("[TB] FAIL fixed%0d_end got sent=%b busy=%b valid=%b pulses=%0d exp 0/0/0/1",
                        v, sent, busy, uartValid, sc);
      end
    end
  endtask

  task automatic test_random_stalls();
    logic [31:0] la, lo;
    bit s, w;
    int fv, sa, sc, se;
    logic bs;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        la = 0; lo = 0; s = 0; w = 0;
      end else begin
        la = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99999999);
        lo = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99999999);
        s  = 1'($urandom_range(0, 1));
        w  = 1'($urandom_range(0, 1));
      end
      build_expected(la, lo, s, w, 1'b1);
      start_send(la, lo, s, w);
      collect(1'b1, 1'b0, 0, fv, sa, sc, se, bs);
      total++;
      if (!seq_match()) begin
        bad++; $display("[TB] FAIL stall%0d_bytes got=%s exp=%s", it, q2str(gotQ), q2str(expQ));
      end
      total++; if (se != 0) begin bad++; $display("[TB] FAIL stall%0d_hold got=%0d unstable exp=0", it, se); end
      total++;
      if (gotQ.size() != expQ.size() || sc != 1) begin
        bad++; $display("[TB] FAIL stall%0d_count got=%0d/%0d exp=%0d/1", it, gotQ.size(), sc, expQ.size());
      end
    end
    uartReady = 1'b1;
  endtask

  task automatic test_busy_ignore();
    int fv, sa, sc, se;
    logic bs;
    build_expected(32'd4815162, 32'd23420001, 1'b1, 1'b1, 1'b1);
    start_send(32'd4815162, 32'd23420001, 1'b1, 1'b1);
    collect(1'b0, 1'b1, 60, fv, sa, sc, se, bs);
    total++;
    if (!seq_match()) begin
      bad++; $display("[TB] FAIL busy_ignore_bytes got=%s exp=%s", q2str(gotQ), q2str(expQ));
    end
    total++;
    if (sc != 1 || sa < 0) begin
      bad++; $display("[TB] FAIL busy_ignore_sent got=%0d pulses exp=1", sc);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_ignore_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int fv, sa, sc, se;
    logic bs;
    build_expected(32'd11111111, 32'd22222222, 1'b0, 1'b1, 1'b1);
    start_send(32'd11111111, 32'd22222222, 1'b0, 1'b1);
    collect(1'b0, 1'b0, 0, fv, sa, sc, se, bs);
    total++;
    if (!seq_match()) begin
      bad++; $display("[TB] FAIL b2b_first got=%s exp=%s", q2str(gotQ), q2str(expQ));
    end
    latitude  = 32'd87654321;
    longitude = 32'd135792468;
    latSouth  = 1'b1;
    lonWest   = 1'b0;
    send      = 1'b1;
    build_expected(32'd87654321, 32'd135792468, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    collect(1'b0, 1'b0, 0, fv, sa, sc, se, bs);
    total++; if (bs !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept got=%b exp=1", bs); end
    total++;
    if (!seq_match() || fv != 28) begin
      bad++; $display("[TB] FAIL b2b_second got=%s lat=%0d exp=%s lat=28", q2str(gotQ), fv, q2str(expQ));
    end
  endtask

  task automatic test_async_reset();
    int xfers = 0;
    int fv, sa, sc, se;
    logic bs;
    uartReady = 1'b1;
    start_send(32'd55555555, 32'd66666666, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      send = 1'b0;
      if (xfers == 15) break;
      if (uartValid === 1'b1) xfers++;
    end
    total++; if (xfers != 15) begin bad++; $display("[TB] FAIL rst_reach got=%0d exp=15", xfers); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (uartValid !== 1'b0 || busy !== 1'b0 || uartData !== 8'h00) begin
      bad++; $display("[TB] FAIL rst_async got valid=%b busy=%b data=%h exp 0/0/00", uartValid, busy, uartData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    build_expected(32'd31415926, 32'd27182818, 1'b1, 1'b1, 1'b1);
    start_send(32'd31415926, 32'd27182818, 1'b1, 1'b1);
    collect(1'b0, 1'b0, 0, fv, sa, sc, se, bs);
    total++;
    if (!seq_match() || fv != 28) begin
      bad++; $display("[TB] FAIL rst_resume got=%s lat=%0d exp=%s lat=28", q2str(gotQ), fv, q2str(expQ));
    end
  endtask

  task automatic test_no_crlf();
    int sa = -1;
    build_expected(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    gotQ.delete();
    @(negedge clk);
    latitude = 0; longitude = 0; latSouth = 0; lonWest = 0;
    send0 = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      send0 = 1'b0;
      if (sent0 === 1'b1) begin sa = cyc; break; end
      if (valid0 === 1'b1) gotQ.push_back(data0);
    end
    total++;
    if (!seq_match()) begin
      bad++; $display("[TB] FAIL nocrlf_bytes got=%s exp=%s", q2str(gotQ), q2str(expQ));
    end
    total++;
    if (gotQ.size() == 0 || gotQ[gotQ.size()-1] !== "1") begin
      bad++; $display("[TB] FAIL nocrlf_last got=%s exp=last '1'", q2str(gotQ));
    end
    total++;
    if (sa != 28 + expQ.size()) begin
      bad++; $display("[TB] FAIL nocrlf_sent_time got=%0d exp=%0d", sa, 28 + expQ.size());
    end
  endtask

  initial begin
    send = 0; send0 = 0; latitude = 0; longitude = 0;
    latSouth = 0; lonWest = 0; uartReady = 1; ready0 = 1;
    test_reset();
    test_fixed_vectors();
    test_random_stalls();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    test_no_crlf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
